// File: rtl/out_layer_collect.sv
// out_layer_collect: accumulates N_IN product terms for each of ten output neurons and packs them for argmax.
// Optional OUT_SAT_EN: saturate each narrowed neuron value instead of wrapping.
module out_layer_collect #(
    parameter int BIT   = 16,
    parameter int N_IN  = 64,
    parameter int ACC_W = 32,
    parameter int SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [BIT-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [10*BIT-1:0]     data_out,
    output logic                  out_valid,
    output logic                  done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int CW = N_IN > 1 ? $clog2(N_IN) : 1;

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc, shifted;
    logic [CW-1:0]           term_cnt;
    logic [3:0]              neuron_cnt;
    logic [BIT-1:0]          narrowed;

    assign in_ready = state == ACCUM;
    assign done     = state == DONE;
    assign shifted  = acc >>> SHIFT;

`ifdef OUT_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (BIT-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    assign narrowed = shifted > MAXV ? MAXV[BIT-1:0] : shifted < MINV ? MINV[BIT-1:0] : shifted[BIT-1:0];
`else
    assign narrowed = shifted[BIT-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            term_cnt   <= '0;
            neuron_cnt <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= ACCUM;
                    acc        <= '0;
                    term_cnt   <= '0;
                    neuron_cnt <= '0;
                    data_out   <= '0;
                    out_valid  <= 1'b0;
                end
                ACCUM: if (in_valid) begin
                    acc      <= acc + ACC_W'(in_data);
                    term_cnt <= term_cnt + 1'b1;
                    state    <= term_cnt == CW'(N_IN - 1) ? STORE : ACCUM;
                end
                STORE: begin
                    // neuron 0 lands in the MSB slice
                    data_out[(4'd9 - neuron_cnt) * BIT +: BIT] <= narrowed;
                    acc        <= '0;
                    term_cnt   <= '0;
                    neuron_cnt <= neuron_cnt == 4'd9 ? neuron_cnt : neuron_cnt + 4'd1;
                    out_valid  <= neuron_cnt == 4'd9;
                    state      <= neuron_cnt == 4'd9 ? DONE : ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_out_layer_collect.sv
// tb_out_layer_collect: random and directed frames on SHIFT=0 and SHIFT=2 instances against a sum-per-neuron reference.
module tb_out_layer_collect;
    localparam int BIT = 16;
    localparam int N   = 4;
    localparam int W   = 10 * BIT;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic signed [BIT-1:0] in_data = '0;
    logic [W-1:0] d0, d2, exp0, exp2;
    logic r0, r2, v0, v2, dn0, dn2;
    logic signed [BIT-1:0] terms [10][N];
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    out_layer_collect #(.BIT(BIT), .N_IN(N), .ACC_W(32), .SHIFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r0), .data_out(d0), .out_valid(v0), .done(dn0));
    out_layer_collect #(.BIT(BIT), .N_IN(N), .ACC_W(32), .SHIFT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r2), .data_out(d2), .out_valid(v2), .done(dn2));

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BIT-1:0] narrow_ref(input longint sum, input int sh);
        longint v = sum >>> sh;
        longint lim = longint'(1) << (BIT - 1);
`ifdef OUT_SAT_EN
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
`endif
        return BIT'(v);
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_data0"}, d0, '0);
        check({tag, "_data2"}, d2, '0);
        check({tag, "_ctl"}, W'({r0, r2, v0, v2, dn0, dn2}), '0);
    endtask

    task automatic run_frame(input bit stalls, input int abort_at, input bit spur_done);
        int edges = 0, stall_tot = 0;
        longint sum;
        exp0 = '0;
        exp2 = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clear0", d0, '0);
        check("start_clear2", d2, '0);
        check("start_ovld", W'({v0, v2}), '0);
        for (int k = 0; k < 10; k++) begin
            sum = 0;
            for (int j = 0; j < N; j++) begin
                int st = stalls ? ((k == 2 && j == 1) ? 3 : ($urandom_range(0, 3) == 0 ? 1 : 0)) : 0;
                repeat (st) begin
                    in_valid = 1'b0;
                    in_data = BIT'($urandom);
                    check("stall_rdy", W'({r0, r2, dn0}), W'(3'b110));
                    tick();
                    edges++;
                    stall_tot++;
                end
                in_valid = 1'b1;
                in_data = terms[k][j];
                start = (k == 4 && j == 1);
                check("accum_rdy", W'({r0, r2, dn0, dn2}), W'(4'b1100));
                tick();
                start = 1'b0;
                edges++;
                sum += longint'(terms[k][j]);
                if (abort_at == k && j == 1) begin
                    #2 rst_n = 1'b0;
                    #1 check_idle_zero("abort");
                    #4 rst_n = 1'b1;
                    in_valid = 1'b0;
                    tick();
                    check_idle_zero("post_abort");
                    return;
                end
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data = BIT'($urandom);
            check("store_rdy", W'({r0, r2}), '0);
            tick();
            edges++;
            exp0[(9 - k) * BIT +: BIT] = narrow_ref(sum, 0);
            exp2[(9 - k) * BIT +: BIT] = narrow_ref(sum, 2);
            check("slot_s0", d0, exp0);
            check("slot_s2", d2, exp2);
            if (k < 9) check("ovld_mid", W'({v0, v2}), '0);
        end
        check("done_pulse", W'({dn0, dn2}), W'(2'b11));
        check("done_ovld", W'({v0, v2}), W'(2'b11));
        check("latency", W'(edges), W'(10 * (N + 1) + stall_tot));
        in_valid = 1'b0;
        start = spur_done;
        tick();
        start = 1'b0;
        check("idle_done", W'({dn0, dn2, r0, r2}), '0);
        check("idle_ovld", W'({v0, v2}), W'(2'b11));
        check("hold_s0", d0, exp0);
        check("hold_s2", d2, exp2);
        tick();
        check("hold2_s0", d0, exp0);
        check("hold2_ovld", W'({v0, v2, dn0}), W'(3'b110));
    endtask

    task automatic rand_terms();
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < N; j++)
                case ($urandom_range(0, 5))
                    0: terms[k][j] = 16'sh7fff;
                    1: terms[k][j] = -16'sh8000;
                    2: terms[k][j] = BIT'($urandom_range(0, 40)) - 16'sd20;
                    default: terms[k][j] = BIT'($urandom);
                endcase
    endtask

    initial begin
        repeat (2) tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
        tick();
        check_idle_zero("after_reset");
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < N; j++) terms[k][j] = BIT'(k);
        run_frame(1'b0, -1, 1'b0);
        run_frame(1'b1, -1, 1'b1);
        rand_terms();
        for (int j = 0; j < N; j++) begin
            terms[0][j] = 16'sh7fff;
            terms[1][j] = -16'sh8000;
            terms[3][j] = j == 3 ? -16'sd3 : 16'sd5;
            terms[4][j] = -16'sd1;
        end
        run_frame(1'b0, -1, 1'b1);
        rand_terms();
        run_frame(1'b1, 5, 1'b0);
        for (int f = 0; f < 5; f++) begin
            rand_terms();
            run_frame(1'b1, -1, 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
